// File: rtl/chroma_key_pkg.sv
// Shared constants for the chroma-key compositor: output modes and config register addresses.
package chroma_key_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t BYPASS = 2'd0;
  localparam mode_t KEY    = 2'd1;
  localparam mode_t MATTE  = 2'd2;
  localparam mode_t BG     = 2'd3;

  localparam logic [1:0] CFG_KEY  = 2'd0;
  localparam logic [1:0] CFG_TOL  = 2'd1;
  localparam logic [1:0] CFG_MODE = 2'd2;

endpackage

// File: rtl/ck_channel_cmp.sv
// Combinational per-channel key test: |px - key| <= tol, unsigned, no wrap-around.
module ck_channel_cmp
  import chroma_key_pkg::*;
#(
  parameter int unsigned CH_W = 8
) (
  input  logic [CH_W-1:0] px,
  input  logic [CH_W-1:0] key,
  input  logic [CH_W-1:0] tol,
  output logic            match
);

  logic [CH_W:0] diff;

  always_comb begin
    if (px >= key) begin
      diff = {1'b0, px} - {1'b0, key};
    end else begin
      diff = {1'b0, key} - {1'b0, px};
    end
    match = (diff <= {1'b0, tol});
  end

endmodule

// File: rtl/chroma_key_mixer.sv
// Two-stage chroma-key compositor joining foreground and background pixel streams.
// Define CHROMA_KEY_MATCH_CNT_EN to add the per-frame matched-pixel counter output match_cnt.
module chroma_key_mixer
  import chroma_key_pkg::*;
#(
  parameter int unsigned CH_W   = 8,
  parameter int unsigned NUM_CH = 3,
  localparam int unsigned DATA_W = NUM_CH * CH_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] fg_data,
  input  logic              fg_valid,
  input  logic              fg_sop,
  input  logic              fg_eop,
  output logic              fg_ready,
  input  logic [DATA_W-1:0] bg_data,
  input  logic              bg_valid,
  input  logic              bg_sop,
  input  logic              bg_eop,
  output logic              bg_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              out_sop,
  output logic              out_eop,
  input  logic              out_ready,
  input  logic              cfg_wr,
  input  logic [1:0]        cfg_addr,
  input  logic [DATA_W-1:0] cfg_wdata,
  output logic [15:0]       sync_err_cnt
`ifdef CHROMA_KEY_MATCH_CNT_EN
  ,
  output logic [31:0]       match_cnt
`endif
);

  // Frame framing comes from the foreground stream only.
  logic unused_bg_eop;
  assign unused_bg_eop = bg_eop;

  logic              run_q;
  logic [DATA_W-1:0] key_sh_q, key_act_q, tol_sh_q, tol_act_q;
  mode_t             mode_sh_q, mode_act_q;

  logic              s1_valid_q, s1_sop_q, s1_eop_q, s1_match_q;
  logic [DATA_W-1:0] s1_fg_q, s1_bg_q;
  mode_t             s1_mode_q;

  logic              advance, s1_load_en, both_valid, join_fire, drop, apply_shadow;
  logic [DATA_W-1:0] key_eff, tol_eff, sel_data;
  mode_t             mode_eff;
  logic [NUM_CH-1:0] ch_match;
  logic              pix_match;

  assign advance    = !out_valid | out_ready;
  assign s1_load_en = advance | !s1_valid_q;
  assign both_valid = run_q & fg_valid & bg_valid & s1_load_en;
  assign join_fire  = both_valid & (fg_sop == bg_sop);
  assign drop       = both_valid & (fg_sop != bg_sop);
  // A lone SOP waits while the other stream's stale beats are flushed.
  assign fg_ready   = both_valid & (!fg_sop | bg_sop);
  assign bg_ready   = both_valid & (fg_sop | !bg_sop);

  // The SOP beat that loads the shadow already sees the shadowed values.
  assign apply_shadow = join_fire & fg_sop;
  assign key_eff      = apply_shadow ? key_sh_q  : key_act_q;
  assign tol_eff      = apply_shadow ? tol_sh_q  : tol_act_q;
  assign mode_eff     = apply_shadow ? mode_sh_q : mode_act_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_cmp
    ck_channel_cmp #(
      .CH_W (CH_W)
    ) u_cmp (
      .px    (fg_data[g*CH_W +: CH_W]),
      .key   (key_eff[g*CH_W +: CH_W]),
      .tol   (tol_eff[g*CH_W +: CH_W]),
      .match (ch_match[g])
    );
  end

  assign pix_match = &ch_match;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_q      <= 1'b0;
      key_sh_q   <= '0;
      tol_sh_q   <= '0;
      mode_sh_q  <= BYPASS;
      key_act_q  <= '0;
      tol_act_q  <= '0;
      mode_act_q <= BYPASS;
    end else begin
      run_q <= 1'b1;
      if (cfg_wr) begin
        case (cfg_addr)
          CFG_KEY:  key_sh_q  <= cfg_wdata;
          CFG_TOL:  tol_sh_q  <= cfg_wdata;
          CFG_MODE: mode_sh_q <= cfg_wdata[1:0];
          default:  ;
        endcase
      end
      if (apply_shadow) begin
        key_act_q  <= key_sh_q;
        tol_act_q  <= tol_sh_q;
        mode_act_q <= mode_sh_q;
      end
    end
  end

  always_comb begin
    sel_data = s1_fg_q;
    case (s1_mode_q)
      BYPASS:  sel_data = s1_fg_q;
      KEY:     sel_data = s1_match_q ? s1_bg_q : s1_fg_q;
      MATTE:   sel_data = s1_match_q ? '1 : '0;
      default: sel_data = s1_bg_q;
    endcase
  end

`ifdef CHROMA_KEY_MATCH_CNT_EN
  logic        s2_match_q;
  logic [31:0] frame_match_q;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q   <= 1'b0;
      s1_fg_q      <= '0;
      s1_bg_q      <= '0;
      s1_sop_q     <= 1'b0;
      s1_eop_q     <= 1'b0;
      s1_match_q   <= 1'b0;
      s1_mode_q    <= BYPASS;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_sop      <= 1'b0;
      out_eop      <= 1'b0;
      sync_err_cnt <= '0;
`ifdef CHROMA_KEY_MATCH_CNT_EN
      s2_match_q    <= 1'b0;
      frame_match_q <= '0;
      match_cnt     <= '0;
`endif
    end else begin
      if (s1_load_en) begin
        s1_valid_q <= join_fire;
        if (join_fire) begin
          s1_fg_q    <= fg_data;
          s1_bg_q    <= bg_data;
          s1_sop_q   <= fg_sop;
          s1_eop_q   <= fg_eop;
          s1_match_q <= pix_match;
          s1_mode_q  <= mode_eff;
        end
      end
      if (advance) begin
        out_valid <= s1_valid_q;
        if (s1_valid_q) begin
          out_data <= sel_data;
          out_sop  <= s1_sop_q;
          out_eop  <= s1_eop_q;
`ifdef CHROMA_KEY_MATCH_CNT_EN
          s2_match_q <= s1_match_q;
`endif
        end
      end
      if (drop && sync_err_cnt != 16'hFFFF) begin
        sync_err_cnt <= sync_err_cnt + 16'd1;
      end
`ifdef CHROMA_KEY_MATCH_CNT_EN
      if (out_valid && out_ready) begin
        if (out_eop) begin
          match_cnt     <= frame_match_q + 32'(s2_match_q);
          frame_match_q <= '0;
        end else begin
          frame_match_q <= frame_match_q + 32'(s2_match_q);
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_chroma_key_mixer.sv
// Self-checking bench for chroma_key_mixer: vector table, corner sequences, randomized frames.
module tb_chroma_key_mixer;
  import chroma_key_pkg::*;

  localparam int DW     = 24;
  localparam int BUDGET = 400;

  typedef struct packed { logic sop; logic eop; logic [DW-1:0] d; } beat_t;
  typedef struct packed {
    logic [1:0] mode; logic [DW-1:0] key, tol, fg, bg, exp_px;
  } vec_t;

  logic          clk, reset_n;
  logic [DW-1:0] fg_data, bg_data, out_data, cfg_wdata;
  logic          fg_valid, fg_sop, fg_eop, fg_ready;
  logic          bg_valid, bg_sop, bg_eop, bg_ready;
  logic          out_valid, out_sop, out_eop, out_ready;
  logic          cfg_wr;
  logic [1:0]    cfg_addr;
  logic [15:0]   sync_err_cnt;
`ifdef CHROMA_KEY_MATCH_CNT_EN
  logic [31:0]   match_cnt;
`endif

  chroma_key_mixer #(.CH_W(8), .NUM_CH(3)) dut (
    .clk(clk), .reset_n(reset_n),
    .fg_data(fg_data), .fg_valid(fg_valid), .fg_sop(fg_sop), .fg_eop(fg_eop),
    .fg_ready(fg_ready),
    .bg_data(bg_data), .bg_valid(bg_valid), .bg_sop(bg_sop), .bg_eop(bg_eop),
    .bg_ready(bg_ready),
    .out_data(out_data), .out_valid(out_valid), .out_sop(out_sop), .out_eop(out_eop),
    .out_ready(out_ready),
    .cfg_wr(cfg_wr), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .sync_err_cnt(sync_err_cnt)
`ifdef CHROMA_KEY_MATCH_CNT_EN
    , .match_cnt(match_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Reference model: plain per-channel distance test and mode select.
  function automatic logic ref_match(input logic [DW-1:0] key, tol, px);
    for (int c = 0; c < 3; c++) begin
      int a, k, t, d;
      a = int'(px[8*c +: 8]);
      k = int'(key[8*c +: 8]);
      t = int'(tol[8*c +: 8]);
      d = (a > k) ? a - k : k - a;
      if (d > t) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic logic [DW-1:0] ref_pix(input logic [1:0] mode, input logic m,
                                            input logic [DW-1:0] fg, bg);
    case (mode)
      BYPASS:  return fg;
      KEY:     return m ? bg : fg;
      MATTE:   return m ? 24'hFFFFFF : 24'h000000;
      default: return bg;
    endcase
  endfunction

  beat_t         fg_q[$], bg_q[$], exp_q[$];
  logic [1:0]    fr_mode[2];
  logic [DW-1:0] fr_key[2], fr_tol[2];
  int            exp_err, exp_mcnt;
  logic          mon_done;

  // Pair beats by SOP alignment; the stream whose head lacks SOP loses that beat.
  task automatic build_expected();
    int i = 0, j = 0, fr = 0, m = 0;
    logic first = 1'b1;
    exp_q.delete(); exp_err = 0; exp_mcnt = 0;
    while (i < fg_q.size() && j < bg_q.size()) begin
      if (fg_q[i].sop == bg_q[j].sop) begin
        logic mt;
        beat_t e;
        if (fg_q[i].sop) begin
          if (!first) fr = 1;
          first = 1'b0;
          m = 0;
        end
        mt = ref_match(fr_key[fr], fr_tol[fr], fg_q[i].d);
        m += int'(mt);
        if (fg_q[i].eop) exp_mcnt = m;
        e.sop = fg_q[i].sop; e.eop = fg_q[i].eop;
        e.d = ref_pix(fr_mode[fr], mt, fg_q[i].d, bg_q[j].d);
        exp_q.push_back(e);
        i++; j++;
      end else begin
        exp_err++;
        if (fg_q[i].sop) j++; else i++;
      end
    end
  endtask

  task automatic drive_fg(input int gap);
    int i = 0, c = 0;
    logic pend = 1'b0;
    while (i < fg_q.size() && c < BUDGET) begin
      @(negedge clk); c++;
      if (!pend && $urandom_range(0, 99) < gap) fg_valid = 1'b0;
      else begin
        fg_valid = 1'b1; fg_data = fg_q[i].d; fg_sop = fg_q[i].sop; fg_eop = fg_q[i].eop;
      end
      #4;
      pend = fg_valid && !fg_ready;
      if (fg_valid && fg_ready) i++;
    end
    @(negedge clk); fg_valid = 1'b0;
  endtask

  task automatic drive_bg(input int gap);
    int i = 0, c = 0;
    logic pend = 1'b0;
    while (i < bg_q.size() && c < BUDGET) begin
      @(negedge clk); c++;
      if (!pend && $urandom_range(0, 99) < gap) bg_valid = 1'b0;
      else begin
        bg_valid = 1'b1; bg_data = bg_q[i].d; bg_sop = bg_q[i].sop; bg_eop = bg_q[i].eop;
      end
      #4;
      pend = bg_valid && !bg_ready;
      if (bg_valid && bg_ready) i++;
    end
    @(negedge clk); bg_valid = 1'b0;
  endtask

  task automatic run_streams(input int fg_gap, bg_gap, or_pct, wr_cyc, input logic [1:0] wr_mode);
    logic [15:0] err0;
    int extra = 0;
    build_expected();
    err0 = sync_err_cnt;
    mon_done = 1'b0;
    fork
      drive_fg(fg_gap);
      drive_bg(bg_gap);
      begin
        while (!mon_done) begin
          @(negedge clk);
          out_ready = ($urandom_range(0, 99) < or_pct);
        end
      end
      begin
        int c = 0;
        while (exp_q.size() > 0 && c < BUDGET) begin
          @(negedge clk); c++;
          #4;
          if (out_valid && out_ready) begin
            beat_t e;
            e = exp_q.pop_front();
            check("stream_out", {out_sop, out_eop, out_data}, e);
          end
        end
        if (exp_q.size() > 0) check("stream_timeout", exp_q.size(), 0);
        mon_done = 1'b1;
      end
      begin
        if (wr_cyc >= 0) begin
          repeat (wr_cyc) @(negedge clk);
          cfg_wr = 1'b1; cfg_addr = CFG_MODE; cfg_wdata = {22'd0, wr_mode};
          @(negedge clk); cfg_wr = 1'b0;
        end
      end
    join
    @(negedge clk); out_ready = 1'b1;
    repeat (4) begin
      @(negedge clk); #4;
      if (out_valid && out_ready) extra++;
    end
    check("no_extra_out", extra, 0);
    check("sync_err_delta", sync_err_cnt - err0, 16'(exp_err));
`ifdef CHROMA_KEY_MATCH_CNT_EN
    check("match_cnt", match_cnt, exp_mcnt);
`endif
  endtask

  task automatic cfg_write(input logic [1:0] addr, input logic [DW-1:0] data);
    @(negedge clk); cfg_wr = 1'b1; cfg_addr = addr; cfg_wdata = data;
    @(negedge clk); cfg_wr = 1'b0;
  endtask

  task automatic set_cfg(input logic [1:0] mode, input logic [DW-1:0] key, tol);
    cfg_write(CFG_MODE, {22'd0, mode});
    cfg_write(CFG_KEY, key);
    cfg_write(CFG_TOL, tol);
  endtask

  task automatic send_single(input logic [DW-1:0] fg, bg, exp_px, input logic wr,
                             input logic [1:0] wmode);
    @(negedge clk);
    out_ready = 1'b1;
    fg_valid = 1'b1; fg_sop = 1'b1; fg_eop = 1'b1; fg_data = fg;
    bg_valid = 1'b1; bg_sop = 1'b1; bg_eop = 1'b1; bg_data = bg;
    if (wr) begin cfg_wr = 1'b1; cfg_addr = CFG_MODE; cfg_wdata = {22'd0, wmode}; end
    #4 check("single_join", {fg_ready, bg_ready}, 2'b11);
    @(negedge clk); fg_valid = 1'b0; bg_valid = 1'b0; cfg_wr = 1'b0;
    #4 check("single_lat1", out_valid, 1'b0);
    @(negedge clk);
    #4 check("single_out", {out_valid, out_sop, out_eop, out_data}, {3'b111, exp_px});
  endtask

  task automatic push_pair(input logic [DW-1:0] fg, bg, input logic sop, eop);
    fg_q.push_back({sop, eop, fg});
    bg_q.push_back({sop, eop, bg});
  endtask

  task automatic gen_frame(input int len, input logic [DW-1:0] key);
    for (int k = 0; k < len; k++) begin
      logic [DW-1:0] f;
      logic near;
      near = ($urandom_range(0, 2) != 0);
      for (int c = 0; c < 3; c++) begin
        int v;
        v = near ? int'(key[8*c +: 8]) + int'($urandom_range(0, 40)) - 20
                 : int'($urandom_range(0, 255));
        if (v < 0) v = 0;
        if (v > 255) v = 255;
        f[8*c +: 8] = 8'(v);
      end
      push_pair(f, 24'($urandom), k == 0, k == len - 1);
    end
  endtask

  vec_t vt[14];

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vt[0]  = '{KEY,    24'h00FF00, 24'h101010, 24'h05F00A, 24'h123456, 24'h123456};
    vt[1]  = '{KEY,    24'h00FF00, 24'h101010, 24'h05E00A, 24'h123456, 24'h05E00A};
    vt[2]  = '{KEY,    24'h00FF00, 24'hFFFFFF, 24'h05E00A, 24'h123456, 24'h123456};
    vt[3]  = '{KEY,    24'h00FF00, 24'hFFFFFF, 24'h000000, 24'hABCDEF, 24'hABCDEF};
    vt[4]  = '{KEY,    24'h00FF00, 24'h000000, 24'h00FF00, 24'h123456, 24'h123456};
    vt[5]  = '{KEY,    24'h00FF00, 24'h000000, 24'h00FE00, 24'h123456, 24'h00FE00};
    vt[6]  = '{BYPASS, 24'h00FF00, 24'h101010, 24'h05F00A, 24'h123456, 24'h05F00A};
    vt[7]  = '{MATTE,  24'h00FF00, 24'h101010, 24'h05F00A, 24'h123456, 24'hFFFFFF};
    vt[8]  = '{MATTE,  24'h00FF00, 24'h101010, 24'h05E00A, 24'h123456, 24'h000000};
    vt[9]  = '{BG,     24'h00FF00, 24'h101010, 24'h05E00A, 24'h123456, 24'h123456};
    vt[10] = '{KEY,    24'h000000, 24'h050505, 24'hFBFBFB, 24'h123456, 24'hFBFBFB};
    vt[11] = '{KEY,    24'h000000, 24'h050505, 24'h030303, 24'h123456, 24'h123456};
    vt[12] = '{KEY,    24'hFFFFFF, 24'h050505, 24'hFAFAFA, 24'h123456, 24'h123456};
    vt[13] = '{KEY,    24'hFFFFFF, 24'h050505, 24'h040404, 24'h123456, 24'h040404};

    reset_n = 1'b1;
    cfg_wr = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    fg_valid = 1'b1; fg_sop = 1'b1; fg_eop = 1'b1; fg_data = 24'h111111;
    bg_valid = 1'b1; bg_sop = 1'b1; bg_eop = 1'b1; bg_data = 24'h222222;
    out_ready = 1'b1;
    #1 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    #4;
    check("reset_out", {out_valid, out_sop, out_eop, out_data}, '0);
    check("reset_ready", {fg_ready, bg_ready}, 2'b00);
    check("reset_sync_err", sync_err_cnt, 16'h0);
`ifdef CHROMA_KEY_MATCH_CNT_EN
    check("reset_match_cnt", match_cnt, 32'h0);
`endif
    @(negedge clk); fg_valid = 1'b0; bg_valid = 1'b0; reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Table vectors: one single-beat frame per entry, config applied at its SOP.
    for (int v = 0; v < 14; v++) begin
      set_cfg(vt[v].mode, vt[v].key, vt[v].tol);
      send_single(vt[v].fg, vt[v].bg, vt[v].exp_px, 1'b0, BYPASS);
    end

    // Mode write landing on the SOP join takes effect from the following frame.
    set_cfg(BYPASS, 24'h00FF00, 24'h101010);
    send_single(24'h05F00A, 24'h123456, 24'h05F00A, 1'b1, BG);
    send_single(24'h05F00A, 24'h123456, 24'h123456, 1'b0, BYPASS);

    // Output stall: 5 cycles of out_ready=0 while offering a 4-pixel frame.
    cfg_write(CFG_MODE, {22'd0, BYPASS});
    begin
      int acc = 0, stall_acc = 0;
      logic [DW-1:0] got[$];
      for (int cy = 0; cy < 14; cy++) begin
        @(negedge clk);
        out_ready = (cy >= 5);
        if (acc < 4) begin
          fg_valid = 1'b1; bg_valid = 1'b1;
          fg_sop = (acc == 0); bg_sop = (acc == 0);
          fg_eop = (acc == 3); bg_eop = (acc == 3);
          fg_data = 24'hA00000 + 24'(acc); bg_data = 24'h0B0000 + 24'(acc);
        end else begin
          fg_valid = 1'b0; bg_valid = 1'b0;
        end
        #4;
        if (fg_valid && fg_ready) begin
          acc++;
          if (cy < 5) stall_acc++;
        end
        if (out_valid && !out_ready) check("stall_hold", out_data, 24'hA00000);
        if (out_valid && out_ready) got.push_back(out_data);
      end
      check("stall_accepts", stall_acc, 2);
      check("stall_out_count", got.size(), 4);
      for (int k = 0; k < 4; k++)
        check("stall_order", (k < got.size()) ? got[k] : 24'hDEAD00, 24'hA00000 + 24'(k));
    end

    // Background SOP three beats ahead of foreground SOP.
    fg_q.delete(); bg_q.delete();
    fr_mode[0] = BYPASS; fr_key[0] = 24'h00FF00; fr_tol[0] = 24'h101010;
    for (int k = 0; k < 3; k++) fg_q.push_back({1'b0, 1'b0, 24'hEE0000 + 24'(k)});
    for (int k = 0; k < 3; k++) push_pair(24'hC00000 + 24'(k), 24'hD00000 + 24'(k), k == 0, k == 2);
    run_streams(0, 0, 100, -1, BYPASS);
    check("resync_cnt", sync_err_cnt, 16'd3);

    // MATTE written mid-frame: first frame stays KEY, second frame is a matte with 4 matches.
    set_cfg(KEY, 24'h00FF00, 24'h101010);
    fg_q.delete(); bg_q.delete();
    fr_mode[0] = KEY;   fr_key[0] = 24'h00FF00; fr_tol[0] = 24'h101010;
    fr_mode[1] = MATTE; fr_key[1] = 24'h00FF00; fr_tol[1] = 24'h101010;
    for (int k = 0; k < 10; k++)
      push_pair(k[0] ? 24'h05E00A : 24'h05F00A, 24'h100000 + 24'(k), k == 0, k == 9);
    for (int k = 0; k < 10; k++)
      push_pair((k == 1 || k == 3 || k == 5 || k == 8) ? 24'h05F00A : 24'h05E00A,
                24'h200000 + 24'(k), k == 0, k == 9);
    run_streams(0, 0, 100, 4, MATTE);
`ifdef CHROMA_KEY_MATCH_CNT_EN
    check("matte_match_cnt", match_cnt, 32'd4);
`endif

    // Randomized frames with leading misaligned beats, input gaps and output back-pressure.
    for (int f = 0; f < 25; f++) begin
      logic [DW-1:0] key, tol;
      logic [1:0] mode;
      int ng;
      mode = 2'($urandom_range(0, 3));
      key  = 24'($urandom);
      case ($urandom_range(0, 3))
        0:       tol = 24'h000000;
        1:       tol = 24'hFFFFFF;
        default: tol = {8'($urandom_range(0, 24)), 8'($urandom_range(0, 24)),
                        8'($urandom_range(0, 24))};
      endcase
      set_cfg(mode, key, tol);
      fr_mode[0] = mode; fr_key[0] = key; fr_tol[0] = tol;
      fg_q.delete(); bg_q.delete();
      ng = $urandom_range(0, 2);
      for (int k = 0; k < ng; k++) begin
        if (f[0]) fg_q.push_back({1'b0, 1'b0, 24'($urandom)});
        else      bg_q.push_back({1'b0, 1'b0, 24'($urandom)});
      end
      gen_frame($urandom_range(1, 6), key);
      run_streams(25, 25, 70, -1, BYPASS);
    end

    // Asynchronous reset while the output is busy.
    @(negedge clk);
    out_ready = 1'b1;
    fg_valid = 1'b1; fg_sop = 1'b1; fg_eop = 1'b1; fg_data = 24'h333333;
    bg_valid = 1'b1; bg_sop = 1'b1; bg_eop = 1'b1; bg_data = 24'h444444;
    repeat (3) @(negedge clk);
    #4 check("pre_reset_valid", out_valid, 1'b1);
    @(negedge clk); reset_n = 1'b0;
    #4;
    check("midreset_out_valid", out_valid, 1'b0);
    check("midreset_fg_ready", fg_ready, 1'b0);
    check("midreset_sync_err", sync_err_cnt, 16'h0);
    @(negedge clk); fg_valid = 1'b0; bg_valid = 1'b0; reset_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
